// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter: S_COUNT AXI4-Stream inputs share one output.
// The grant is held for a whole packet. Beats pass through a 2-entry skid register and carry their source index on tid.
module axis_rr_packet_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [S_COUNT-1:0]              s_axis_tvalid,
    output logic [S_COUNT-1:0]              s_axis_tready,
    input  logic [S_COUNT-1:0]              s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [ID_WIDTH-1:0]             m_axis_tid,
    output logic [USER_WIDTH-1:0]           m_axis_tuser,
    output logic                            busy,
    output logic [ID_WIDTH-1:0]             grant_idx
);

    localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + USER_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [ID_WIDTH-1:0] grant_r, grant_s;
    logic [ID_WIDTH-1:0] last_grant_r, last_grant_s;
    logic [ID_WIDTH-1:0] sel_idx_s;
    logic                sel_found_s;
    logic                accept_s;
    logic [BEAT_W-1:0]   in_beat_s;
    logic [BEAT_W-1:0]   out_beat_r;
    logic [BEAT_W-1:0]   skid_beat_r;
    logic                out_valid_r;
    logic                skid_valid_r;

    // The input side is open only while a grant is active and the skid entry is free
    assign accept_s  = (state_r == XFER) && s_axis_tvalid[grant_r] && !skid_valid_r;
    assign in_beat_s = {s_axis_tdata[grant_r*DATA_WIDTH +: DATA_WIDTH],
                        s_axis_tkeep[grant_r*KEEP_WIDTH +: KEEP_WIDTH],
                        s_axis_tlast[grant_r],
                        grant_r,
                        s_axis_tuser[grant_r*USER_WIDTH +: USER_WIDTH]};

    // Round-robin pick: first requester at or after last_grant+1, wrapping
    always_comb begin
        int cand;
        cand        = 0;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        for (int i = 1; i <= S_COUNT; i++) begin
            cand = (int'(last_grant_r) + i) % S_COUNT;
            if (!sel_found_s && s_axis_tvalid[cand]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = ID_WIDTH'(cand);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Next-state and grant update for the IDLE/XFER arbiter
    always_comb begin
        state_s      = state_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (sel_found_s) begin
                    state_s      = XFER;
                    grant_s      = sel_idx_s;
                    last_grant_s = sel_idx_s;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                if (accept_s && s_axis_tlast[grant_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = XFER;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Arbiter state register; last_grant resets to the top index so stream 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            last_grant_r <= ID_WIDTH'(S_COUNT - 1);
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
        end
    end

    // One-hot ready towards the grantee only
    always_comb begin
        s_axis_tready = '0;
        if ((state_r == XFER) && !skid_valid_r) begin
            s_axis_tready[grant_r] = 1'b1;
        end else begin
            s_axis_tready = '0;
        end
    end

    // Output register plus one skid entry; the skid always drains before new input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_beat_r   <= '0;
            skid_beat_r  <= '0;
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!out_valid_r || m_axis_tready) begin
            if (skid_valid_r) begin
                out_beat_r   <= skid_beat_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                out_beat_r  <= in_beat_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_beat_r  <= in_beat_s;
            skid_valid_r <= 1'b1;
        end else begin
            skid_valid_r <= skid_valid_r;
        end
    end

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser} = out_beat_r;
    assign m_axis_tvalid = out_valid_r;
    assign busy          = (state_r == XFER);
    assign grant_idx     = grant_r;

endmodule
